// File: rtl/mdu_pkg.sv
// Shared definitions for the mdu_hilo multiply/divide unit:
// the op encoding, the FSM state enum and the iteration-counter width helper.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_t;

    // The counter has to be able to hold DATA_WIDTH itself, hence the +1.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider for mdu_hilo: one quotient bit per step on unsigned magnitudes.
// The quotient register shifts the dividend out and the quotient bits in.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int W = DATA_WIDTH;

    logic [W-1:0] quo_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] dsr_q;
    logic [W:0]   shifted;
    logic         fits;
    logic [W-1:0] trial;

    // When the trial fits, shifted < 2*divisor, so the difference always fits in W bits.
    assign shifted = {rem_q, quo_q[W-1]};
    assign fits    = (shifted >= {1'b0, dsr_q});
    assign trial   = shifted[W-1:0] - dsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (step) begin
            if (fits) begin
                rem_q <= trial;
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= shifted[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with its own HI/LO pair and a start/busy/done handshake.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU complete at once with div_zero=1.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] HI_out,
    output logic [DATA_WIDTH-1:0] LO_out
);

    localparam int W     = DATA_WIDTH;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = cnt_width(DATA_WIDTH);

    mdu_state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     hi_q, lo_q, hi_next, lo_next;
    logic [W-1:0]     a_mag;
    logic             a_neg, b_neg;
    logic [PW-1:0]    prod, prod_fix;
    logic [W:0]       mul_sum;
    logic             load, step;
    logic             busy_next, done_next, div_zero_next;
    logic [W-1:0]     hi_fix, lo_fix;
    logic             dz_fix;

    logic             is_mul_op, is_div_op, signed_op, arith_op;
    logic             a_sign_in, b_sign_in;
    logic [W-1:0]     a_abs, b_abs;

    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);

`ifdef MDU_DIV_EN
    assign arith_op = is_mul_op || is_div_op;
`else
    assign arith_op = is_mul_op;
`endif

    // Both datapaths work on magnitudes; signs are reapplied in FIX.
    assign a_sign_in = signed_op & A[W-1];
    assign b_sign_in = signed_op & B[W-1];
    assign a_abs     = a_sign_in ? -A : A;
    assign b_abs     = b_sign_in ? -B : B;

    assign mul_sum = {1'b0, prod[PW-1:W]} + {1'b0, a_mag & {W{prod[0]}}};

`ifdef MDU_DIV_EN
    logic         is_div_q;
    logic         b_zero_q;
    logic [W-1:0] quo, rem;

    mdu_divider #(
        .DATA_WIDTH(W)
    ) u_divider (
        .clk      (CLK),
        .rst      (RST),
        .load     (load),
        .step     (step),
        .dividend (a_abs),
        .divisor  (b_abs),
        .quotient (quo),
        .remainder(rem)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
        end else if (load) begin
            is_div_q <= is_div_op;
            b_zero_q <= (B == '0);
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= busy_next;
            done     <= done_next;
            div_zero <= div_zero_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            a_mag <= '0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            prod  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (load) begin
                cnt   <= '0;
                a_mag <= a_abs;
                a_neg <= a_sign_in;
                b_neg <= b_sign_in;
                prod  <= {{W{1'b0}}, b_abs};
            end else if (step) begin
                cnt   <= cnt + CNT_W'(1);
                prod  <= {mul_sum, prod[W-1:1]};
            end
            hi_q <= hi_next;
            lo_q <= lo_next;
        end
    end

    // Divide by zero returns the original A in HI; most-negative / -1 falls out of the normal path.
    always_comb begin
        prod_fix = (a_neg ^ b_neg) ? -prod : prod;
        hi_fix   = prod_fix[PW-1:W];
        lo_fix   = prod_fix[W-1:0];
        dz_fix   = 1'b0;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
            if (b_zero_q) begin
                lo_fix = '1;
                hi_fix = a_neg ? -a_mag : a_mag;
                dz_fix = 1'b1;
            end else begin
                lo_fix = (a_neg ^ b_neg) ? -quo : quo;
                hi_fix = a_neg ? -rem : rem;
            end
        end
`endif
    end

    always_comb begin
        state_next    = state;
        done_next     = 1'b0;
        div_zero_next = 1'b0;
        load          = 1'b0;
        step          = 1'b0;
        hi_next       = hi_q;
        lo_next       = lo_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (arith_op) begin
                        load       = 1'b1;
                        state_next = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_next   = A;
                        done_next = 1'b1;
                    end else if (op == OP_MTLO) begin
                        lo_next   = A;
                        done_next = 1'b1;
                    end
`ifndef MDU_DIV_EN
                    else if (is_div_op) begin
                        done_next     = 1'b1;
                        div_zero_next = 1'b1;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(W - 1)) begin
                        state_next = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_next = ST_IDLE;
                if (!flush) begin
                    hi_next       = hi_fix;
                    lo_next       = lo_fix;
                    done_next     = 1'b1;
                    div_zero_next = dz_fix;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy_next = (state_next != ST_IDLE);
    assign HI_out    = hi_q;
    assign LO_out    = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo (DATA_WIDTH=32): directed ops, a cycle-level reference model
// compared every cycle, and literal expectations; follows MDU_DIV_EN like the design.
module tb_mdu_hilo;

    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int DIV_LAT = DIV_EN ? 34 : 1;

    logic         CLK   = 1'b0;
    logic         RST   = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic         flush = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] HI_out, LO_out;

    int checks   = 0;
    int failures = 0;

    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dz   = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;
    logic         p_dz   = 1'b0;
    int           m_left = 0;

    mdu_hilo #(
        .DATA_WIDTH(W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .op      (op),
        .flush   (flush),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero),
        .HI_out  (HI_out),
        .LO_out  (LO_out)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural result of one HI/LO op, straight from the instruction definitions.
    function automatic void modelResult(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                        output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        logic [2*W-1:0] p;
        p  = '0;
        h  = '0;
        l  = '0;
        dz = 1'b0;
        case (o)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                h = p[2*W-1:W];
                l = p[W-1:0];
            end
            3'd1: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                h = p[2*W-1:W];
                l = p[W-1:0];
            end
            3'd2: begin
                if (b == '0) begin
                    l = '1; h = a; dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = a; h = '0;
                end else begin
                    l = $signed(a) / $signed(b);
                    h = $signed(a) % $signed(b);
                end
            end
            3'd3: begin
                if (b == '0) begin
                    l = '1; h = a; dz = 1'b1;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Cycle-level reference: tracks when the architectural result becomes visible.
    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
                m_hi = '0; m_lo = '0; m_left = 0;
            end else begin
                m_done = 1'b0;
                m_dz   = 1'b0;
                if (!m_busy) begin
                    if (start && op <= 3'd5) begin
                        if (op == 3'd4) begin
                            m_hi = A; m_done = 1'b1;
                        end else if (op == 3'd5) begin
                            m_lo = A; m_done = 1'b1;
                        end else if (op[1] && !DIV_EN) begin
                            m_done = 1'b1; m_dz = 1'b1;
                        end else begin
                            modelResult(op, A, B, p_hi, p_lo, p_dz);
                            m_busy = 1'b1;
                            m_left = W + 1;
                        end
                    end
                end else if (flush) begin
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
                        m_done = 1'b1; m_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (RST === 1'b0) begin
                checkOutput("model_busy", W'(busy), W'(m_busy));
                checkOutput("model_done", W'(done), W'(m_done));
                checkOutput("model_hi", HI_out, m_hi);
                checkOutput("model_lo", LO_out, m_lo);
                if (m_done) checkOutput("model_div_zero", W'(div_zero), W'(m_dz));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=no done expected=done within 100 cycles");
        end
    endtask

    initial begin
        int n;
        int done_seen;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        checkOutput("reset_hi", HI_out, '0);
        checkOutput("reset_lo", LO_out, '0);
        checkOutput("reset_busy", W'(busy), '0);
        checkOutput("reset_done", W'(done), '0);
        checkOutput("reset_div_zero", W'(div_zero), '0);

        applyStimulus(3'd0, 32'hFFFF_FFFE, 32'd3);
        checkOutput("mult_busy_after_accept", W'(busy), 32'd1);
        waitDone(n);
        checkOutput("mult_latency", W'(n), 32'd34);
        checkOutput("mult_hi", HI_out, 32'hFFFF_FFFF);
        checkOutput("mult_lo", LO_out, 32'hFFFF_FFFA);
        checkOutput("mult_busy_at_done", W'(busy), 32'd0);

        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(n);
        checkOutput("multu_b2b_latency", W'(n), 32'd34);
        checkOutput("multu_hi", HI_out, 32'hFFFF_FFFE);
        checkOutput("multu_lo", LO_out, 32'h0000_0001);

        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
        waitDone(n);
        checkOutput("div_latency", W'(n), W'(DIV_LAT));
        checkOutput("div_lo", LO_out, DIV_EN ? 32'hFFFF_FFFD : 32'h0000_0001);
        checkOutput("div_hi", HI_out, DIV_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
        checkOutput("div_dz", W'(div_zero), W'(!DIV_EN));

        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(n);
        checkOutput("div_ovf_lo", LO_out, DIV_EN ? 32'h8000_0000 : 32'h0000_0001);
        checkOutput("div_ovf_hi", HI_out, DIV_EN ? 32'h0000_0000 : 32'hFFFF_FFFE);

        applyStimulus(3'd3, 32'd5, 32'd0);
        waitDone(n);
        checkOutput("divu_zero_lo", LO_out, DIV_EN ? 32'hFFFF_FFFF : 32'h0000_0001);
        checkOutput("divu_zero_hi", HI_out, DIV_EN ? 32'h0000_0005 : 32'hFFFF_FFFE);
        checkOutput("divu_zero_flag", W'(div_zero), 32'd1);

        applyStimulus(3'd2, 32'd7, 32'hFFFF_FFFE);
        waitDone(n);
        checkOutput("div_neg_divisor_lo", LO_out, DIV_EN ? 32'hFFFF_FFFD : 32'h0000_0001);
        checkOutput("div_neg_divisor_hi", HI_out, DIV_EN ? 32'h0000_0001 : 32'hFFFF_FFFE);

        applyStimulus(3'd3, 32'd100, 32'd7);
        waitDone(n);

        applyStimulus(3'd6, 32'hAAAA_AAAA, 32'd1);
        checkOutput("noop_done", W'(done), 32'd0);
        checkOutput("noop_busy", W'(busy), 32'd0);

        applyStimulus(3'd4, 32'h0000_1234, 32'd0);
        waitDone(n);
        checkOutput("mthi_latency", W'(n), 32'd1);
        checkOutput("mthi_hi", HI_out, 32'h0000_1234);

        applyStimulus(3'd0, 32'd3, 32'd5);
        repeat (4) @(negedge CLK);
        applyStimulus(3'd5, 32'h0000_DEAD, 32'd0);
        repeat (4) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        checkOutput("flush_busy", W'(busy), 32'd0);
        checkOutput("flush_hi", HI_out, 32'h0000_1234);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge CLK);
        end
        checkOutput("flush_no_done", W'(done_seen), 32'd0);

        start = 1'b1; flush = 1'b1; op = 3'd1; A = 32'd7; B = 32'd6;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        waitDone(n);
        checkOutput("start_beats_flush_latency", W'(n), 32'd34);
        checkOutput("start_beats_flush_lo", LO_out, 32'h0000_002A);
        checkOutput("start_beats_flush_hi", HI_out, 32'h0000_0000);

        applyStimulus(3'd5, 32'h0000_CAFE, 32'd0);
        waitDone(n);
        checkOutput("mtlo_lo", LO_out, 32'h0000_CAFE);

        applyStimulus(3'd3, 32'd100, 32'd7);
        repeat (4) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        checkOutput("async_reset_hi", HI_out, '0);
        checkOutput("async_reset_lo", LO_out, '0);
        checkOutput("async_reset_busy", W'(busy), '0);
        @(negedge CLK);
        RST = 1'b0;

        applyStimulus(3'd1, 32'h0001_0000, 32'h0003_0000);
        waitDone(n);
        checkOutput("post_reset_latency", W'(n), 32'd34);
        checkOutput("post_reset_hi", HI_out, 32'h0000_0003);
        checkOutput("post_reset_lo", LO_out, 32'h0000_0000);

        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
